// File: rtl/wash_cycle_scheduler_if.sv
// Panel/sensor inputs and actuator/status outputs of the wash sequencer.
// master drives the panel side, slave is the scheduler.
interface wash_cycle_scheduler_if #(
    parameter int CNT_W = 8
);
    logic             tick;
    logic             start;
    logic             pause;
    logic             door_closed;
    logic             level_ok;
    logic [1:0]       prog;
    logic             fault_clr;
    logic             extra_rinse;

    logic [2:0]       stage;
    logic [CNT_W-1:0] remaining;
    logic             busy;
    logic             paused;
    logic             done;
    logic             fault;
    logic             valve_on;
    logic             motor_on;
    logic             pump_on;

    modport master (
        output tick, start, pause, door_closed, level_ok, prog, fault_clr, extra_rinse,
        input  stage, remaining, busy, paused, done, fault, valve_on, motor_on, pump_on
    );

    modport slave (
        input  tick, start, pause, door_closed, level_ok, prog, fault_clr, extra_rinse,
        output stage, remaining, busy, paused, done, fault, valve_on, motor_on, pump_on
    );
endinterface

// File: rtl/wash_cycle_scheduler.sv
// Washing-machine stage sequencer FILL/WASH/RINSE/SPIN/DRAIN; optional EXTRA_RINSE_EN adds a second RINSE.
// Latency: every input acts on the next clk edge; all outputs registered.
// Backpressure: none; pause or open door freezes the cycle with actuators off.
module wash_cycle_scheduler #(
    parameter int CNT_W   = 8,
    parameter int FILL_TO = 10,
    parameter int WASH_T  = 6,
    parameter int RINSE_T = 4,
    parameter int SPIN_T  = 4,
    parameter int DRAIN_T = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    wash_cycle_scheduler_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PAUSED,
        S_DONE,
        S_FAULT
    } state_t;

    localparam logic [2:0]       STG_FILL  = 3'd0;
    localparam logic [2:0]       STG_WASH  = 3'd1;
    localparam logic [2:0]       STG_RINSE = 3'd2;
    localparam logic [2:0]       STG_SPIN  = 3'd3;
    localparam logic [2:0]       STG_DRAIN = 3'd4;
    localparam logic [2:0]       STG_NONE  = 3'd7;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] FILL_LD   = CNT_W'(FILL_TO);
    localparam logic [CNT_W-1:0] DRAIN_LD  = CNT_W'(DRAIN_T);

    // quick halves, heavy doubles; result clamped to [1, CNT_MAX]
    function automatic logic [CNT_W-1:0] scale_dur(input logic [31:0] base, input logic [1:0] p);
        logic [32:0]      v;
        logic [CNT_W-1:0] r;
        case (p)
            2'd0:    v = {1'b0, base} >> 1;
            2'd2:    v = {base, 1'b0};
            default: v = {1'b0, base};
        endcase
        if (v > {{(33-CNT_W){1'b0}}, CNT_MAX}) r = CNT_MAX;
        else if (v == 33'd0)                   r = ONE;
        else                                   r = v[CNT_W-1:0];
        return r;
    endfunction

    // {valve, motor, pump} for a running stage
    function automatic logic [2:0] act_for(input logic [2:0] s);
        return {s == STG_FILL, s inside {STG_WASH, STG_RINSE, STG_SPIN}, s == STG_DRAIN};
    endfunction

    state_t           state;
    logic [2:0]       stage_q;
    logic [CNT_W-1:0] rem_q;
    logic [1:0]       prog_q;
    logic             busy_q;
    logic             paused_q;
    logic             done_q;
    logic             fault_q;
    logic [2:0]       act_q;

    logic [2:0]       adv_stage;
    logic [CNT_W-1:0] adv_rem;
    logic             adv_done;

`ifdef EXTRA_RINSE_EN
    logic             xr_pend;
    logic             adv_xr_use;
`else
    logic             unused_extra_rinse;
    assign unused_extra_rinse = bus.extra_rinse;
`endif

    // Where the current stage goes when it finishes
    always_comb begin
        adv_stage = stage_q;
        adv_rem   = rem_q;
        adv_done  = 1'b0;
`ifdef EXTRA_RINSE_EN
        adv_xr_use = 1'b0;
`endif
        case (stage_q)
            STG_FILL: begin
                adv_stage = STG_WASH;
                adv_rem   = scale_dur(32'(WASH_T), prog_q);
            end
            STG_WASH: begin
                adv_stage = STG_RINSE;
                adv_rem   = scale_dur(32'(RINSE_T), prog_q);
            end
            STG_RINSE: begin
`ifdef EXTRA_RINSE_EN
                if (xr_pend) begin
                    adv_stage  = STG_RINSE;
                    adv_rem    = scale_dur(32'(RINSE_T), prog_q);
                    adv_xr_use = 1'b1;
                end else begin
                    adv_stage = STG_SPIN;
                    adv_rem   = scale_dur(32'(SPIN_T), prog_q);
                end
`else
                adv_stage = STG_SPIN;
                adv_rem   = scale_dur(32'(SPIN_T), prog_q);
`endif
            end
            STG_SPIN: begin
                adv_stage = STG_DRAIN;
                adv_rem   = DRAIN_LD;
            end
            default: begin
                adv_stage = STG_NONE;
                adv_rem   = '0;
                adv_done  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            stage_q  <= STG_NONE;
            rem_q    <= '0;
            prog_q   <= 2'd1;
            busy_q   <= 1'b0;
            paused_q <= 1'b0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
            act_q    <= 3'b000;
`ifdef EXTRA_RINSE_EN
            xr_pend  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start && bus.door_closed && !bus.pause) begin
                        state   <= S_RUN;
                        prog_q  <= bus.prog;
                        stage_q <= STG_FILL;
                        rem_q   <= FILL_LD;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        act_q   <= act_for(STG_FILL);
`ifdef EXTRA_RINSE_EN
                        xr_pend <= bus.extra_rinse;
`endif
                    end
                end
                S_RUN: begin
                    if (bus.pause || !bus.door_closed) begin
                        state    <= S_PAUSED;
                        paused_q <= 1'b1;
                        act_q    <= 3'b000;
                    end else if ((stage_q == STG_FILL && bus.level_ok) ||
                                 (bus.tick && stage_q != STG_FILL && rem_q <= ONE)) begin
                        stage_q <= adv_stage;
                        rem_q   <= adv_rem;
`ifdef EXTRA_RINSE_EN
                        if (adv_xr_use) xr_pend <= 1'b0;
`endif
                        if (adv_done) begin
                            state  <= S_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            act_q  <= 3'b000;
                        end else begin
                            act_q  <= act_for(adv_stage);
                        end
                    end else if (bus.tick) begin
                        if (rem_q > ONE) begin
                            rem_q <= rem_q - ONE;
                        end else begin
                            // drum never reported full within the fill window
                            state   <= S_FAULT;
                            stage_q <= STG_NONE;
                            rem_q   <= '0;
                            busy_q  <= 1'b0;
                            fault_q <= 1'b1;
                            act_q   <= 3'b000;
                        end
                    end
                end
                S_PAUSED: begin
                    if (bus.start && !bus.pause && bus.door_closed) begin
                        state    <= S_RUN;
                        paused_q <= 1'b0;
                        act_q    <= act_for(stage_q);
                    end
                end
                S_FAULT: begin
                    if (bus.fault_clr) begin
                        state   <= S_IDLE;
                        fault_q <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    stage_q  <= STG_NONE;
                    rem_q    <= '0;
                    busy_q   <= 1'b0;
                    paused_q <= 1'b0;
                    done_q   <= 1'b0;
                    fault_q  <= 1'b0;
                    act_q    <= 3'b000;
                end
            endcase
        end
    end

    assign bus.stage     = stage_q;
    assign bus.remaining = rem_q;
    assign bus.busy      = busy_q;
    assign bus.paused    = paused_q;
    assign bus.done      = done_q;
    assign bus.fault     = fault_q;
    assign bus.valve_on  = act_q[2];
    assign bus.motor_on  = act_q[1];
    assign bus.pump_on   = act_q[0];

endmodule
